// File: rtl/usb_desc_rom_reader.sv
// Descriptor ROM reader: resolves a GET_DESCRIPTOR request through the ROM LUT,
// fetches the descriptor length and streams min(length, wLength) bytes in EP0 packets.
module usb_desc_rom_reader #(
   parameter int ROM_ADDR_WID    = 8,
   parameter int ROM_IDX_BYTES   = 1,
   parameter int NUM_CONFIGS     = 1,
   parameter int NUM_STRINGS     = 5,
   parameter int MAX_PACKET_SIZE = 64
) (
   input  logic                    clk48,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [7:0]              req_type,
   input  logic [7:0]              req_index,
   input  logic [15:0]             req_length,
   input  logic                    abort,
   output logic [ROM_ADDR_WID-1:0] rom_addr,
   input  logic [7:0]              rom_data,
   output logic [7:0]              out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_pkt_last,
   output logic                    zlp_req,
   output logic                    req_stall,
   output logic                    busy
);

   localparam int AW = ROM_ADDR_WID;
   localparam int IW = ROM_IDX_BYTES * 8;
   localparam int PW = $clog2(MAX_PACKET_SIZE);
   localparam int CW = (ROM_IDX_BYTES > 2) ? $clog2(ROM_IDX_BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LUT_RD,
      S_HDR_RD,
      S_CFG_LEN_RD,
      S_STREAM
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rom_addr_q, rom_addr_d;
   logic            rd_vld_q, rd_vld_d;
   logic [1:0]      rd_tag_q, rd_tag_d;
   logic            dat_vld_q, dat_vld_d;
   logic [1:0]      dat_tag_q, dat_tag_d;
   logic            is_cfg_q, is_cfg_d;
   logic [15:0]     req_len_q, req_len_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   lut_acc_q, lut_acc_d;
   logic [AW-1:0]   nxt_addr_q, nxt_addr_d;
   logic [7:0]      cfg_lo_q, cfg_lo_d;
   logic [15:0]     rem_q, rem_d;
   logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
   logic            zlp_need_q, zlp_need_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic            out_final_q, out_final_d;
   logic [9:0]      fifo_q [2];
   logic [9:0]      fifo_d [2];
   logic            fifo_wp_q, fifo_wp_d;
   logic            fifo_rp_q, fifo_rp_d;
   logic [1:0]      fifo_cnt_q, fifo_cnt_d;
   logic            zlp_req_q, zlp_req_d;
   logic            stall_q, stall_d;

   logic            req_ready_w;
   logic            accept;
   logic            req_ok;
   logic [AW-1:0]   entry_sel;
   logic [AW-1:0]   lut_addr;
   logic [IW-1:0]   acc_new;
   logic            go_stream;
   logic [15:0]     new_len;
   logic [15:0]     total;
   logic            pop;
   logic            push;
   logic            fifo_pop;
   logic            arrive;
   logic [9:0]      arrive_word;
   logic [2:0]      occ;
   logic            credit_ok;

   assign req_ready_w = (state_q == S_IDLE) && !abort;

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      rd_vld_d    = 1'b0;
      rd_tag_d    = 2'b00;
      dat_vld_d   = rd_vld_q;
      dat_tag_d   = rd_tag_q;
      is_cfg_d    = is_cfg_q;
      req_len_d   = req_len_q;
      idx_d       = idx_q;
      lut_acc_d   = lut_acc_q;
      nxt_addr_d  = nxt_addr_q;
      cfg_lo_d    = cfg_lo_q;
      rem_d       = rem_q;
      pkt_cnt_d   = pkt_cnt_q;
      zlp_need_d  = zlp_need_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_final_d = out_final_q;
      fifo_d      = fifo_q;
      fifo_wp_d   = fifo_wp_q;
      fifo_rp_d   = fifo_rp_q;
      fifo_cnt_d  = fifo_cnt_q;
      zlp_req_d   = 1'b0;
      stall_d     = 1'b0;
      go_stream   = 1'b0;
      new_len     = 16'd0;
      total       = 16'd0;
      push        = 1'b0;
      fifo_pop    = 1'b0;

      accept = req_valid && req_ready_w;
      req_ok = (req_type == 8'd1)
             || ((req_type == 8'd2) && (int'(req_index) < NUM_CONFIGS))
             || ((req_type == 8'd3) && (NUM_STRINGS > 0) && (int'(req_index) <= NUM_STRINGS));
      case (req_type)
         8'd2:    entry_sel = AW'(1) + AW'(req_index);
         8'd3:    entry_sel = AW'(NUM_CONFIGS + 1) + AW'(req_index);
         default: entry_sel = '0;
      endcase
      lut_addr = entry_sel * AW'(ROM_IDX_BYTES);

      acc_new = lut_acc_q;
      for (int k = 0; k < ROM_IDX_BYTES; k++) begin
         if (idx_q == CW'(k)) acc_new[k*8 +: 8] = rom_data;
      end

      // Slots = output register + 2-entry buffer; reads in flight hold a slot each.
      pop       = out_valid_q && out_ready;
      occ       = 3'(out_valid_q) + 3'(fifo_cnt_q) + 3'(rd_vld_q) + 3'(dat_vld_q) - 3'(pop);
      credit_ok = (occ < 3'd3);
      arrive      = dat_vld_q && (state_q == S_STREAM);
      arrive_word = {dat_tag_q, rom_data};

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!req_ok) begin
                  stall_d = 1'b1;
               end else if (req_length == 16'd0) begin
                  zlp_req_d = 1'b1;
               end else begin
                  state_d    = S_LUT_RD;
                  is_cfg_d   = (req_type == 8'd2);
                  req_len_d  = req_length;
                  idx_d      = '0;
                  lut_acc_d  = '0;
                  rom_addr_d = lut_addr;
                  rd_vld_d   = 1'b1;
               end
            end
         end
         S_LUT_RD: begin
            if (dat_vld_q) begin
               lut_acc_d = acc_new;
               rd_vld_d  = 1'b1;
               if (idx_q == CW'(ROM_IDX_BYTES - 1)) begin
                  state_d    = S_HDR_RD;
                  nxt_addr_d = acc_new[AW-1:0];
                  rom_addr_d = acc_new[AW-1:0];
               end else begin
                  idx_d      = idx_q + CW'(1);
                  rom_addr_d = rom_addr_q + AW'(1);
               end
            end
         end
         S_HDR_RD: begin
            if (dat_vld_q) begin
               if (is_cfg_q) begin
                  state_d    = S_CFG_LEN_RD;
                  idx_d      = '0;
                  rom_addr_d = nxt_addr_q + AW'(2);
                  rd_vld_d   = 1'b1;
               end else begin
                  go_stream = 1'b1;
                  new_len   = {8'h00, rom_data};
               end
            end
         end
         S_CFG_LEN_RD: begin
            if (dat_vld_q) begin
               if (idx_q == '0) begin
                  cfg_lo_d   = rom_data;
                  idx_d      = CW'(1);
                  rom_addr_d = rom_addr_q + AW'(1);
                  rd_vld_d   = 1'b1;
               end else begin
                  go_stream = 1'b1;
                  new_len   = {rom_data, cfg_lo_q};
               end
            end
         end
         S_STREAM: begin
            if ((rem_q != 16'd0) && credit_ok) begin
               rom_addr_d = nxt_addr_q;
               rd_vld_d   = 1'b1;
               rd_tag_d   = {(rem_q == 16'd1),
                             (pkt_cnt_q == PW'(MAX_PACKET_SIZE - 1)) || (rem_q == 16'd1)};
               nxt_addr_d = nxt_addr_q + AW'(1);
               rem_d      = rem_q - 16'd1;
               pkt_cnt_d  = pkt_cnt_q + PW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (go_stream) begin
         total      = (new_len < req_len_q) ? new_len : req_len_q;
         rem_d      = total;
         pkt_cnt_d  = '0;
         zlp_need_d = (total < req_len_q) && (total[PW-1:0] == '0) && (total != 16'd0);
         state_d    = (total == 16'd0) ? S_IDLE : S_STREAM;
      end

      // Refill the output register from the buffer first so byte order is preserved.
      if (!out_valid_q || pop) begin
         if (fifo_cnt_q != 2'd0) begin
            {out_final_d, out_last_d, out_data_d} = fifo_q[fifo_rp_q];
            out_valid_d = 1'b1;
            fifo_pop    = 1'b1;
            push        = arrive;
         end else if (arrive) begin
            {out_final_d, out_last_d, out_data_d} = arrive_word;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_final_d = 1'b0;
         end
      end else begin
         push = arrive;
      end
      if (push) begin
         fifo_d[fifo_wp_q] = arrive_word;
         fifo_wp_d         = ~fifo_wp_q;
      end
      if (fifo_pop) fifo_rp_d = ~fifo_rp_q;
      fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(fifo_pop);

      if (pop && out_final_q) begin
         state_d   = S_IDLE;
         zlp_req_d = zlp_need_q;
      end

      if (abort) begin
         state_d     = S_IDLE;
         rd_vld_d    = 1'b0;
         dat_vld_d   = 1'b0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         out_final_d = 1'b0;
         fifo_cnt_d  = 2'd0;
         fifo_wp_d   = 1'b0;
         fifo_rp_d   = 1'b0;
         zlp_req_d   = 1'b0;
         stall_d     = 1'b0;
      end
   end

   always_ff @(posedge clk48) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rom_addr_q  <= '0;
         rd_vld_q    <= 1'b0;
         rd_tag_q    <= 2'b00;
         dat_vld_q   <= 1'b0;
         dat_tag_q   <= 2'b00;
         is_cfg_q    <= 1'b0;
         req_len_q   <= 16'd0;
         idx_q       <= '0;
         lut_acc_q   <= '0;
         nxt_addr_q  <= '0;
         cfg_lo_q    <= 8'd0;
         rem_q       <= 16'd0;
         pkt_cnt_q   <= '0;
         zlp_need_q  <= 1'b0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_final_q <= 1'b0;
         fifo_q[0]   <= 10'd0;
         fifo_q[1]   <= 10'd0;
         fifo_wp_q   <= 1'b0;
         fifo_rp_q   <= 1'b0;
         fifo_cnt_q  <= 2'd0;
         zlp_req_q   <= 1'b0;
         stall_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         rd_vld_q    <= rd_vld_d;
         rd_tag_q    <= rd_tag_d;
         dat_vld_q   <= dat_vld_d;
         dat_tag_q   <= dat_tag_d;
         is_cfg_q    <= is_cfg_d;
         req_len_q   <= req_len_d;
         idx_q       <= idx_d;
         lut_acc_q   <= lut_acc_d;
         nxt_addr_q  <= nxt_addr_d;
         cfg_lo_q    <= cfg_lo_d;
         rem_q       <= rem_d;
         pkt_cnt_q   <= pkt_cnt_d;
         zlp_need_q  <= zlp_need_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_final_q <= out_final_d;
         fifo_q[0]   <= fifo_d[0];
         fifo_q[1]   <= fifo_d[1];
         fifo_wp_q   <= fifo_wp_d;
         fifo_rp_q   <= fifo_rp_d;
         fifo_cnt_q  <= fifo_cnt_d;
         zlp_req_q   <= zlp_req_d;
         stall_q     <= stall_d;
      end
   end

   assign req_ready    = req_ready_w;
   assign busy         = (state_q != S_IDLE);
   assign rom_addr     = rom_addr_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign out_pkt_last = out_last_q;
   assign zlp_req      = zlp_req_q;
   assign req_stall    = stall_q;

endmodule

// File: tb/tb_usb_desc_rom_reader.sv
// Bench for usb_desc_rom_reader: two instances (max packet 64 and 8) share stimulus
// and are scored against a descriptor-level model of the ROM image.
module tb_usb_desc_rom_reader;

   logic clk48 = 1'b0;
   always #5 clk48 = ~clk48;

   logic        rst;
   logic        req_valid;
   logic [7:0]  req_type;
   logic [7:0]  req_index;
   logic [15:0] req_length;
   logic        abort;
   logic        out_ready;

   logic [1:0]  req_ready_v, out_valid_v, out_pkt_last_v, zlp_req_v, req_stall_v, busy_v;
   logic [15:0] rom_addr_v, rom_data_v, out_data_v;

   logic [7:0]  rom [256];

   always @(posedge clk48) begin
      rom_data_v[7:0]  <= rom[rom_addr_v[7:0]];
      rom_data_v[15:8] <= rom[rom_addr_v[15:8]];
   end

   usb_desc_rom_reader #(.ROM_ADDR_WID(8), .ROM_IDX_BYTES(1), .NUM_CONFIGS(1),
                         .NUM_STRINGS(5), .MAX_PACKET_SIZE(64)) dut_mps64 (
      .clk48(clk48), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_v[0]),
      .req_type(req_type), .req_index(req_index), .req_length(req_length), .abort(abort),
      .rom_addr(rom_addr_v[7:0]), .rom_data(rom_data_v[7:0]), .out_data(out_data_v[7:0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_pkt_last(out_pkt_last_v[0]),
      .zlp_req(zlp_req_v[0]), .req_stall(req_stall_v[0]), .busy(busy_v[0]));

   usb_desc_rom_reader #(.ROM_ADDR_WID(8), .ROM_IDX_BYTES(1), .NUM_CONFIGS(1),
                         .NUM_STRINGS(5), .MAX_PACKET_SIZE(8)) dut_mps8 (
      .clk48(clk48), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_v[1]),
      .req_type(req_type), .req_index(req_index), .req_length(req_length), .abort(abort),
      .rom_addr(rom_addr_v[15:8]), .rom_data(rom_data_v[15:8]), .out_data(out_data_v[15:8]),
      .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_pkt_last(out_pkt_last_v[1]),
      .zlp_req(zlp_req_v[1]), .req_stall(req_stall_v[1]), .busy(busy_v[1]));

   int         checks = 0;
   int         failures = 0;
   int         exp_n [2];
   int         got_n [2];
   logic [7:0] exp_byte [2][256];
   logic       exp_last [2][256];
   logic [7:0] got_byte [2][256];
   logic       got_last [2][256];
   int         exp_zlp [2];
   int         zlp_seen [2];
   int         stall_seen [2];
   int         exp_stall;
   int         busy_seen;
   logic       stuck [2];
   logic [8:0] stuck_word [2];
   bit         toggle_mode;

   logic [7:0] dev_img [18];
   logic [7:0] cfg_hdr [9];
   logic [7:0] lut_img [8];
   logic [7:0] str_len [5];

   task automatic chk(input string name, input int act, input int req_v);
      checks++;
      if (act != req_v) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
      end
   endtask

   // One clock: score outputs on the falling edge, then advance past the rising edge.
   task automatic tick();
      logic [8:0] word;
      @(negedge clk48);
      for (int d = 0; d < 2; d++) begin
         word = {out_pkt_last_v[d], out_data_v[d*8 +: 8]};
         if (stuck[d]) begin
            chk($sformatf("hold_valid_d%0d", d), int'(out_valid_v[d]), 1);
            chk($sformatf("hold_word_d%0d", d), int'(word), int'(stuck_word[d]));
         end
         if (out_valid_v[d] && out_ready && !abort) begin
            if (got_n[d] < exp_n[d]) begin
               chk($sformatf("byte%0d_d%0d", got_n[d], d), int'(word[7:0]), int'(exp_byte[d][got_n[d]]));
               chk($sformatf("last%0d_d%0d", got_n[d], d), int'(word[8]), int'(exp_last[d][got_n[d]]));
            end else begin
               chk($sformatf("extra_byte_d%0d", d), got_n[d] + 1, exp_n[d]);
            end
            if (got_n[d] < 256) begin
               got_byte[d][got_n[d]] = word[7:0];
               got_last[d][got_n[d]] = word[8];
            end
            got_n[d]++;
         end
         stuck[d]      = out_valid_v[d] && !out_ready && !abort;
         stuck_word[d] = word;
         if (zlp_req_v[d]) begin
            chk($sformatf("zlp_after_last_d%0d", d), got_n[d], exp_n[d]);
            zlp_seen[d]++;
         end
         if (req_stall_v[d]) stall_seen[d]++;
         if (busy_v[d]) busy_seen++;
         chk($sformatf("req_ready_d%0d", d), int'(req_ready_v[d]), int'(!busy_v[d] && !abort));
      end
      @(posedge clk48);
      #1;
      out_ready = toggle_mode ? ~out_ready : 1'b1;
   endtask

   // Expected transfer from the descriptor rules applied to the ROM image.
   task automatic build_model(input int t, input int i, input int len);
      int mps, entry, start, dlen, total;
      bit ok;
      ok = (t == 1) || (t == 2 && i < 1) || (t == 3 && i <= 5);
      exp_stall = ok ? 0 : 1;
      for (int d = 0; d < 2; d++) begin
         mps = (d == 0) ? 64 : 8;
         exp_n[d] = 0;
         exp_zlp[d] = 0;
         got_n[d] = 0;
         zlp_seen[d] = 0;
         stall_seen[d] = 0;
         if (ok && len == 0) begin
            exp_zlp[d] = 1;
         end else if (ok) begin
            entry = (t == 1) ? 0 : (t == 2) ? 1 + i : 2 + i;
            start = int'(rom[entry]);
            if (t == 2) dlen = int'(rom[(start + 2) % 256]) + 256 * int'(rom[(start + 3) % 256]);
            else        dlen = int'(rom[start]);
            total = (dlen < len) ? dlen : len;
            exp_n[d] = total;
            for (int k = 0; k < total; k++) begin
               exp_byte[d][k] = rom[(start + k) % 256];
               exp_last[d][k] = ((k + 1) % mps == 0) || (k == total - 1);
            end
            exp_zlp[d] = (total < len && total % mps == 0 && total > 0) ? 1 : 0;
         end
      end
      busy_seen = 0;
   endtask

   task automatic send_req(input int t, input int i, input int len);
      build_model(t, i, len);
      chk("req_ready_before_req", int'(req_ready_v[0] & req_ready_v[1]), 1);
      req_type   = 8'(t);
      req_index  = 8'(i);
      req_length = 16'(len);
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic run_req(input int t, input int i, input int len);
      int cyc;
      bit done;
      send_req(t, i, len);
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 2000) begin
         tick();
         cyc++;
         done = 1'b1;
         for (int d = 0; d < 2; d++) begin
            if (busy_v[d] || got_n[d] != exp_n[d] || zlp_seen[d] < exp_zlp[d] || stall_seen[d] < exp_stall)
               done = 1'b0;
         end
      end
      chk("txn_timeout", int'(done), 1);
      for (int k = 0; k < 4; k++) tick();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("count_d%0d", d), got_n[d], exp_n[d]);
         chk($sformatf("zlp_count_d%0d", d), zlp_seen[d], exp_zlp[d]);
         chk($sformatf("stall_count_d%0d", d), stall_seen[d], exp_stall);
      end
      $display("TXN type=%0d idx=%0d wlen=%0d bytes64=%0d bytes8=%0d zlp64=%0d zlp8=%0d stall=%0d ready_toggle=%0d",
               t, i, len, got_n[0], got_n[1], zlp_seen[0], zlp_seen[1], stall_seen[0], toggle_mode);
   endtask

   initial begin
      dev_img = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34,
                  8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
      cfg_hdr = '{8'h09, 8'h02, 8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32};
      lut_img = '{8'd8, 8'd26, 8'd58, 8'd62, 8'd67, 8'd73, 8'd81, 8'd91};
      str_len = '{8'd5, 8'd6, 8'd8, 8'd10, 8'd12};
      for (int a = 0; a < 256; a++) rom[a] = 8'(a) ^ 8'h5A;
      for (int a = 0; a < 8; a++)  rom[a] = lut_img[a];
      for (int a = 0; a < 18; a++) rom[8 + a] = dev_img[a];
      for (int a = 0; a < 9; a++)  rom[26 + a] = cfg_hdr[a];
      rom[58] = 8'h04; rom[59] = 8'h03; rom[60] = 8'h09; rom[61] = 8'h08;
      for (int s = 0; s < 5; s++) begin
         rom[lut_img[3 + s]]     = str_len[s];
         rom[lut_img[3 + s] + 1] = 8'h03;
      end

      rst = 1'b1; req_valid = 1'b0; req_type = 8'd0; req_index = 8'd0; req_length = 16'd0;
      abort = 1'b0; out_ready = 1'b1; toggle_mode = 1'b0;
      for (int d = 0; d < 2; d++) begin
         stuck[d] = 1'b0; got_n[d] = 0; exp_n[d] = 0; zlp_seen[d] = 0; stall_seen[d] = 0;
      end
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_req_ready_d%0d", d), int'(req_ready_v[d]), 1);
         chk($sformatf("rst_out_valid_d%0d", d), int'(out_valid_v[d]), 0);
         chk($sformatf("rst_pkt_last_d%0d", d), int'(out_pkt_last_v[d]), 0);
         chk($sformatf("rst_busy_d%0d", d), int'(busy_v[d]), 0);
         chk($sformatf("rst_zlp_d%0d", d), int'(zlp_req_v[d]), 0);
         chk($sformatf("rst_stall_d%0d", d), int'(req_stall_v[d]), 0);
         chk($sformatf("rst_rom_addr_d%0d", d), int'(rom_addr_v[d*8 +: 8]), 0);
      end
      rst = 1'b0;
      repeat (2) tick();

      run_req(1, 0, 64);
      chk("dev_len", got_n[0], 18);
      chk("dev_b0", int'(got_byte[0][0]), 'h12);
      chk("dev_b1", int'(got_byte[0][1]), 'h01);
      chk("dev_last17", int'(got_last[0][17]), 1);
      chk("dev_last16", int'(got_last[0][16]), 0);
      chk("dev_mps8_last7", int'(got_last[1][7]), 1);

      run_req(2, 0, 9);
      chk("cfg9_len", got_n[0], 9);
      chk("cfg9_b0", int'(got_byte[0][0]), 'h09);
      chk("cfg9_b1", int'(got_byte[0][1]), 'h02);
      chk("cfg9_b2", int'(got_byte[0][2]), 'h20);
      chk("cfg9_b3", int'(got_byte[0][3]), 'h00);
      chk("cfg9_last8", int'(got_last[0][8]), 1);

      run_req(2, 0, 255);
      chk("cfg255_len_mps8", got_n[1], 32);
      chk("cfg255_last7", int'(got_last[1][7]), 1);
      chk("cfg255_last15", int'(got_last[1][15]), 1);
      chk("cfg255_last23", int'(got_last[1][23]), 1);
      chk("cfg255_last31", int'(got_last[1][31]), 1);
      chk("cfg255_last30", int'(got_last[1][30]), 0);
      chk("cfg255_zlp_mps8", zlp_seen[1], 1);
      chk("cfg255_zlp_mps64", zlp_seen[0], 0);

      run_req(2, 0, 32);
      chk("cfg32_zlp_mps8", zlp_seen[1], 0);

      run_req(3, 1, 255);
      chk("str1_len", got_n[0], 5);
      chk("str1_b0", int'(got_byte[0][0]), 'h05);
      chk("str1_b1", int'(got_byte[0][1]), 'h03);

      run_req(3, 0, 255);
      chk("str0_b0", int'(got_byte[0][0]), 'h04);
      chk("str0_b1", int'(got_byte[0][1]), 'h03);
      chk("str0_b2", int'(got_byte[0][2]), 'h09);
      chk("str0_b3", int'(got_byte[0][3]), 'h08);

      run_req(3, 5, 255);
      chk("str5_len", got_n[0], 12);

      run_req(1, 0, 16);
      chk("dev16_zlp_mps8", zlp_seen[1], 0);

      run_req(3, 6, 64);
      chk("stall_str6", stall_seen[0], 1);
      chk("stall_str6_busy", busy_seen, 0);
      run_req(2, 1, 64);
      chk("stall_cfg1", stall_seen[1], 1);
      chk("stall_cfg1_busy", busy_seen, 0);
      run_req(7, 0, 64);
      chk("stall_type7", stall_seen[0], 1);
      chk("stall_type7_busy", busy_seen, 0);

      run_req(1, 0, 0);
      chk("wlen0_zlp", zlp_seen[0] + zlp_seen[1], 2);
      chk("wlen0_busy", busy_seen, 0);

      toggle_mode = 1'b1;
      run_req(1, 0, 64);
      chk("toggle_len", got_n[0], 18);

      send_req(1, 0, 64);
      begin
         int cyc = 0;
         while (got_n[0] < 5 && cyc < 500) begin
            tick();
            cyc++;
         end
         chk("abort_reach5_timeout", int'(got_n[0] >= 5), 1);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("abort_valid_d%0d", d), int'(out_valid_v[d]), 0);
         chk($sformatf("abort_busy_d%0d", d), int'(busy_v[d]), 0);
      end
      repeat (4) tick();
      chk("abort_no_zlp", zlp_seen[0] + zlp_seen[1], 0);
      chk("abort_no_more", int'(out_valid_v[0] | out_valid_v[1]), 0);
      $display("TXN abort after byte %0d, bytes64=%0d bytes8=%0d", 5, got_n[0], got_n[1]);
      toggle_mode = 1'b0;

      run_req(1, 0, 64);
      chk("post_abort_b0", int'(got_byte[0][0]), 'h12);
      chk("post_abort_b0_mps8", int'(got_byte[1][0]), 'h12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/usb_desc_rom_reader.md
Name: usb_desc_rom_reader

Overview:
- Reader side of the descriptor ROM image built by the descriptor/ROM-sizing package. The ROM holds a LUT of descriptor start addresses followed by the packed descriptors.
- On a GET_DESCRIPTOR request from the EP0 control logic, the block resolves the LUT entry and fetches the descriptor length.
- It then streams min(descriptor length, wLength) bytes to the EP0 IN path, split into max-packet-size chunks, and requests a trailing zero-length packet (ZLP) when needed.

Parameters:
- ROM_ADDR_WID, 8: ROM byte address width.
- ROM_IDX_BYTES, 1: bytes per LUT entry, little-endian; must equal ceil(ROM_ADDR_WID/8).
- NUM_CONFIGS, 1: configuration descriptor count.
- NUM_STRINGS, 5: string descriptor count, excluding string zero; 0 means no strings.
- MAX_PACKET_SIZE, 64: EP0 max packet size (8/16/32/64).

Ports:
- clk48  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  descriptor request valid
- req_ready  out  1  block idle, accepts request
- req_type  in  8  wValue high byte (1=device, 2=config, 3=string)
- req_index  in  8  wValue low byte
- req_length  in  16  wLength
- abort  in  1  new SETUP seen; cancel current transfer
- rom_addr  out  ROM_ADDR_WID  sync ROM address
- rom_data  in  8  ROM data, valid 1 cycle after rom_addr
- out_data  out  8  descriptor byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte
- out_pkt_last  out  1  qualifies out_data as last byte of current packet
- zlp_req  out  1  1-cycle pulse: send ZLP after last packet
- req_stall  out  1  1-cycle pulse: unsupported request, EP0 must STALL
- busy  out  1  not idle

Behaviour:
- Reset: state IDLE; req_ready=1; out_valid=0; out_pkt_last=0; zlp_req=0; req_stall=0; busy=0; rom_addr=0. Any byte buffer is emptied.
- The ROM is synchronous, with 1-cycle read latency. The LUT starts at address 0.
- LUT order:
  - entry 0: device descriptor
  - entries 1..NUM_CONFIGS: configurations
  - entry NUM_CONFIGS+1: string zero
  - following entries: strings 1..NUM_STRINGS
- Request decode, on the cycle req_valid && req_ready:
  - type 1: LUT entry 0. Type 1 with any index is accepted and req_index is ignored.
  - type 2: entry 1+index; requires index < NUM_CONFIGS.
  - type 3: entry NUM_CONFIGS+1+index; requires NUM_STRINGS>0 and index <= NUM_STRINGS.
  - Anything else: req_stall pulses the next cycle; the block stays IDLE.
  - req_length=0: no bytes are streamed and zlp_req pulses. This is a status-stage-only transfer.
- States: IDLE -> LUT_RD -> HDR_RD -> [CFG_LEN_RD] -> STREAM -> IDLE.
  - LUT_RD: read ROM_IDX_BYTES bytes at entry*ROM_IDX_BYTES and assemble the little-endian start address.
  - HDR_RD: read byte 0 (bLength). For configuration descriptors, go to CFG_LEN_RD.
  - CFG_LEN_RD: read bytes 2,3 (wTotalLength, LE); this replaces bLength as the length.
  - STREAM: remaining = min(length, req_length), 16-bit unsigned compare. Bytes are read sequentially from the start address.
- Output handshake:
  - A byte transfers when out_valid && out_ready.
  - out_data, out_valid and out_pkt_last stay stable while out_valid && !out_ready.
  - Sustained throughput with out_ready held high is 1 byte/cycle after the first byte. This requires a 2-entry prefetch buffer covering ROM latency.
- Packetization:
  - A byte counter wraps at MAX_PACKET_SIZE.
  - out_pkt_last=1 on byte MAX_PACKET_SIZE of each packet and on the final byte of the transfer.
- ZLP: when the final byte is accepted, zlp_req pulses the next cycle if all of the following hold; the block returns to IDLE in the same cycle:
  - sent count < req_length,
  - sent count is a multiple of MAX_PACKET_SIZE,
  - sent count > 0.
- abort (any state):
  - Next cycle: IDLE, out_valid=0, buffer flushed, no zlp_req.
  - abort has priority over a simultaneous req_valid, which is not accepted.
- busy = (state != IDLE); req_ready = !busy && !abort.
- ROM address arithmetic is modulo 2^ROM_ADDR_WID. No wrap detection is required; the ROM image is assumed well formed by construction.

Test Plan:
- Default ROM, type 1, wLength=64 -> 18 bytes, first 0x12,0x01. out_pkt_last only on byte 18; no zlp_req.
- Type 2 idx 0, wLength=9 -> 9 bytes (truncated), first 0x09,0x02,0x20,0x00. out_pkt_last on byte 9.
- Type 2 idx 0, wLength=255, MAX_PACKET_SIZE=8 -> 32 bytes. out_pkt_last on bytes 8,16,24,32; zlp_req pulse after byte 32.
- Type 3 idx 1, wLength=255 -> 5 bytes starting 0x05,0x03. Type 3 idx 0 -> string-zero bytes 0x04,0x03,0x09,0x08.
- Type 3 idx 6, type 2 idx 1, type 7 -> req_stall 1-cycle pulse each; no out_valid; req_ready stays 1.
- Device request with out_ready toggling 1/0 each cycle -> byte sequence identical to the stalled-free run. Then abort after byte 5 -> out_valid=0 next cycle and IDLE; a following type 1 request streams from byte 0x12 again.
